wca_mp: RTL
===========

# wca_mp

Multi-port weight cache between the flag/weight buffer and the PE rows. It serves NUM_PORT independent weight-address streams from a fully associative cache of 2**DEPTH_W entries with FIFO replacement. Each miss is merged across ports and issued as a single outstanding read to the Weight Buffer. A bypass mode disables lookup and fill. Saturating hit/miss counters support performance profiling.

## Interface
- NUM_PORT, 4, number of PE-row ports (≥2)
- ADDR_W, 8, weight address width
- DATA_W, 8, weight data width
- DEPTH_W, 4, log2 cache entries
- CNT_W, 16, hit/miss counter width
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cfg_vld  in  1  config strobe; in WORK requests shutdown
- cfg_byp  in  1  1 = bypass mode
- cfg_rdy  out  1  high in IDLE
- per_adr_vld  in  NUM_PORT  per-port address valid
- per_adr  in  NUM_PORT*ADDR_W  per-port address (port p at [p*ADDR_W +: ADDR_W])
- per_adr_rdy  out  NUM_PORT  address accept
- per_dat_vld  out  NUM_PORT  response valid
- per_dat  out  NUM_PORT*DATA_W  response data
- per_dat_rdy  in  NUM_PORT  response accept
- wbf_adr_vld / wbf_adr / wbf_adr_rdy  out/out/in  1/ADDR_W/1  read request to Weight Buffer
- wbf_dat_vld / wbf_dat / wbf_dat_rdy  in/in/out  1/DATA_W/1  read data from Weight Buffer
- hit_cnt, miss_cnt  out  CNT_W each  saturating counters

## Operation
- Top FSM: IDLE -(cfg_vld)-> CFG -> WORK -(cfg_vld)-> DRAIN -(miss FSM idle, no pend, all per_dat_vld low)-> IDLE.
- CFG latches cfg_byp and clears both counters. IDLE invalidates all entries, clears fill_ptr, pend and output registers. Counters hold in IDLE.
- Per port p, per_adr_rdy[p] = WORK & !pend[p] & (!per_dat_vld[p] | per_dat_rdy[p]). All ports are accepted in parallel.
- Lookup on accept uses the valid entries' tags, pre-update for the current cycle.
  - Hit: the port's output register loads the entry data. hit_cnt+1.
  - Forward hit: the address equals the address being filled this cycle. The output register loads wbf_dat. This counts as a hit.
  - Miss: pend[p]=1 and padr[p] is stored. In bypass, every accept is a miss.
- Miss FSM M_IDLE -> M_REQ -> M_WAIT -> M_IDLE:
  - M_IDLE: a round-robin arbiter selects one pend port that is not in flight. The grant pointer advances past the winner. Go to M_REQ with madr = padr[winner].
  - M_REQ: wbf_adr_vld=1, wbf_adr=madr. On wbf_adr_rdy, go to M_WAIT and miss_cnt+1.
  - M_WAIT: wbf_dat_rdy=1. On wbf_dat_vld, complete every port with pend & padr==madr; each loads wbf_dat and clears pend.
- A miss accepted while madr is in flight with an equal address merges and completes on that fill. It is not re-requested.
- Fill (non-bypass only): write madr/wbf_dat to the entry at fill_ptr, set its valid bit, fill_ptr+1 mod 2**DEPTH_W. When full, this overwrites the oldest entry (FIFO).
- Counters saturate at 2**CNT_W-1.

## Timing
- Reset values:
  - cfg_rdy=1.
  - All other outputs 0: per_adr_rdy, per_dat_vld, per_dat, wbf_adr_vld, wbf_adr, wbf_dat_rdy, hit_cnt, miss_cnt.
- Hit latency: per_dat_vld rises 1 cycle after the accept edge.
- Miss latency: per_dat_vld rises 1 cycle after the wbf_dat handshake. Minimum latency from accept is 4 cycles.
- Output register holds until per_dat_rdy. Back-to-back hits at 1/cycle/port when per_dat_rdy stays high.
- wbf_adr_vld is held stable with madr until wbf_adr_rdy. At most one read is outstanding.
- A lookup hitting the entry overwritten in the same cycle returns the old data, consistent with pre-update lookup.
- cfg_vld in WORK: accepts stop the next cycle. An in-flight miss and pending ports complete in DRAIN.
- Reset mid-operation clears everything asynchronously. An in-flight read is abandoned.

## Test plan
- Config non-bypass; port0 reads 0x10 twice → first is a miss: wbf_adr=0x10, returns 0xA5, miss_cnt=1. Second is a hit returning 0xA5 1 cycle after accept, hit_cnt=1.
- Ports 0–3 all request 0x22 on the same cycle → exactly one WBF read and miss_cnt=1. All four per_dat=0x5C complete on the same cycle.
- DEPTH_W=2; fill 0x01..0x04, then 0x05 → 0x01 evicted. A re-read of 0x01 misses (miss_cnt=6); 0x03 still hits.
- Bypass mode; port1 reads 0x30 three times → three WBF reads, hit_cnt=0, miss_cnt=3, no fill. After returning to non-bypass, 0x30 misses.
- Hold per_dat_rdy[2]=0 with a response pending → per_dat_vld[2] and per_dat[2] stay stable and per_adr_rdy[2]=0 until release.
- Ports 0 and 1 both miss on different addresses → served in round-robin order 0 then 1. cfg_vld mid-miss → DRAIN completes both before IDLE and cfg_rdy=1.

Source files
------------

// File: rtl/wca_mp.sv
// wca_mp: multi-port weight cache. Fully associative, FIFO replacement; misses from
// all ports are merged into a single outstanding Weight Buffer read.

module wca_mp_port #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int NE     = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_clr,
  input  logic                        i_work,
  input  logic                        i_byp,
  input  logic                        i_adr_vld,
  input  logic [ADDR_W-1:0]           i_adr,
  output logic                        o_adr_rdy,
  output logic                        o_dat_vld,
  output logic [DATA_W-1:0]           o_dat,
  input  logic                        i_dat_rdy,
  input  logic [NE-1:0]               i_tvld,
  input  logic [NE-1:0][ADDR_W-1:0]   i_tag,
  input  logic [NE-1:0][DATA_W-1:0]   i_tdat,
  input  logic                        i_fill,
  input  logic [ADDR_W-1:0]           i_madr,
  input  logic [DATA_W-1:0]           i_wdat,
  output logic                        o_hit,
  output logic                        o_pend,
  output logic [ADDR_W-1:0]           o_padr
);
  logic              r_pend, r_vld;
  logic [ADDR_W-1:0] r_padr;
  logic [DATA_W-1:0] r_dat;
  logic              w_acc, w_hit, w_done;
  logic [DATA_W-1:0] w_hdat;

  assign o_adr_rdy = i_work & ~r_pend & (~r_vld | i_dat_rdy);
  assign w_acc     = i_adr_vld & o_adr_rdy;
  assign w_done    = i_fill & r_pend & (r_padr == i_madr);
  assign o_hit     = w_acc & w_hit;
  assign o_pend    = r_pend;
  assign o_padr    = r_padr;
  assign o_dat_vld = r_vld;
  assign o_dat     = r_dat;

  // Lookup sees the table as it was before this cycle's fill
  always_comb begin
    w_hit  = 1'b0;
    w_hdat = '0;
    if (!i_byp) begin
      for (int e = 0; e < NE; e++)
        if (i_tvld[e] && i_tag[e] == i_adr) begin
          w_hit  = 1'b1;
          w_hdat = i_tdat[e];
        end
      if (!w_hit && i_fill && i_madr == i_adr) begin
        w_hit  = 1'b1;
        w_hdat = i_wdat;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= 1'b0;
      r_vld  <= 1'b0;
      r_padr <= '0;
      r_dat  <= '0;
    end else if (i_clr) begin
      r_pend <= 1'b0;
      r_vld  <= 1'b0;
      r_padr <= '0;
      r_dat  <= '0;
    end else begin
      if (w_acc && w_hit) begin
        r_vld <= 1'b1;
        r_dat <= w_hdat;
      end else if (w_done) begin
        r_vld <= 1'b1;
        r_dat <= i_wdat;
      end else if (i_dat_rdy) begin
        r_vld <= 1'b0;
      end
      if (w_acc && !w_hit) begin
        r_pend <= 1'b1;
        r_padr <= i_adr;
      end else if (w_done) begin
        r_pend <= 1'b0;
      end
    end
  end
endmodule

module wca_mp #(
  parameter int NUM_PORT = 4,
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int DEPTH_W  = 4,
  parameter int CNT_W    = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cfg_vld,
  input  logic                         cfg_byp,
  output logic                         cfg_rdy,
  input  logic [NUM_PORT-1:0]          per_adr_vld,
  input  logic [NUM_PORT*ADDR_W-1:0]   per_adr,
  output logic [NUM_PORT-1:0]          per_adr_rdy,
  output logic [NUM_PORT-1:0]          per_dat_vld,
  output logic [NUM_PORT*DATA_W-1:0]   per_dat,
  input  logic [NUM_PORT-1:0]          per_dat_rdy,
  output logic                         wbf_adr_vld,
  output logic [ADDR_W-1:0]            wbf_adr,
  input  logic                         wbf_adr_rdy,
  input  logic                         wbf_dat_vld,
  input  logic [DATA_W-1:0]            wbf_dat,
  output logic                         wbf_dat_rdy,
  output logic [CNT_W-1:0]             hit_cnt,
  output logic [CNT_W-1:0]             miss_cnt
);
  localparam int NE = 2**DEPTH_W;
  localparam int PW = $clog2(NUM_PORT);
  localparam int HW = $clog2(NUM_PORT+1);

  typedef enum logic [1:0] {S_IDLE, S_CFG, S_WORK, S_DRAIN} st_t;
  typedef enum logic [1:0] {M_IDLE, M_REQ, M_WAIT} mst_t;

  st_t                          r_st, w_st_nxt;
  mst_t                         r_mst, w_mst_nxt;
  logic                         r_byp;
  logic [NE-1:0]                r_tvld;
  logic [NE-1:0][ADDR_W-1:0]    r_tag;
  logic [NE-1:0][DATA_W-1:0]    r_tdat;
  logic [DEPTH_W-1:0]           r_fptr;
  logic [ADDR_W-1:0]            r_madr;
  logic [PW-1:0]                r_gptr;
  logic [CNT_W-1:0]             r_hit_cnt, r_miss_cnt;
  logic                         w_clr, w_work, w_fill, w_any;
  logic [PW-1:0]                w_win, w_idx;
  logic [NUM_PORT-1:0]          w_hit, w_pend;
  logic [NUM_PORT-1:0][ADDR_W-1:0] w_padr;
  logic [HW-1:0]                w_nhit;
  logic [CNT_W:0]               w_hsum;

  assign w_fill   = (r_mst == M_WAIT) & wbf_dat_vld;
  assign wbf_adr  = r_madr;
  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;

  // Top FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_st <= S_IDLE;
    else        r_st <= w_st_nxt;
  end

  always_comb begin
    w_st_nxt = r_st;
    case (r_st)
      S_IDLE:  if (cfg_vld) w_st_nxt = S_CFG;
      S_CFG:   w_st_nxt = S_WORK;
      S_WORK:  if (cfg_vld) w_st_nxt = S_DRAIN;
      S_DRAIN: if (r_mst == M_IDLE && w_pend == '0 && per_dat_vld == '0) w_st_nxt = S_IDLE;
      default: w_st_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cfg_rdy = (r_st == S_IDLE);
    w_clr   = (r_st == S_IDLE);
    w_work  = (r_st == S_WORK);
  end

  // Miss FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_mst <= M_IDLE;
    else        r_mst <= w_mst_nxt;
  end

  always_comb begin
    w_mst_nxt = r_mst;
    case (r_mst)
      M_IDLE:  if (w_any) w_mst_nxt = M_REQ;
      M_REQ:   if (wbf_adr_rdy) w_mst_nxt = M_WAIT;
      M_WAIT:  if (wbf_dat_vld) w_mst_nxt = M_IDLE;
      default: w_mst_nxt = M_IDLE;
    endcase
  end

  always_comb begin
    wbf_adr_vld = (r_mst == M_REQ);
    wbf_dat_rdy = (r_mst == M_WAIT);
  end

  // Round-robin pick among pending ports, starting at the grant pointer
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    w_idx = '0;
    for (int i = 0; i < NUM_PORT; i++) begin
      w_idx = PW'((int'(r_gptr) + i) % NUM_PORT);
      if (!w_any && w_pend[w_idx]) begin
        w_any = 1'b1;
        w_win = w_idx;
      end
    end
  end

  // Grant pointer restarts at port 0 each session so service order is reproducible
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_madr <= '0;
      r_gptr <= '0;
    end else if (r_st == S_IDLE) begin
      r_gptr <= '0;
    end else if (r_mst == M_IDLE && w_any) begin
      r_madr <= w_padr[w_win];
      r_gptr <= PW'((int'(w_win) + 1) % NUM_PORT);
    end
  end

  for (genvar p = 0; p < NUM_PORT; p++) begin : g_port
    wca_mp_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NE(NE)) u_port (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_clr     (w_clr),
      .i_work    (w_work),
      .i_byp     (r_byp),
      .i_adr_vld (per_adr_vld[p]),
      .i_adr     (per_adr[p*ADDR_W +: ADDR_W]),
      .o_adr_rdy (per_adr_rdy[p]),
      .o_dat_vld (per_dat_vld[p]),
      .o_dat     (per_dat[p*DATA_W +: DATA_W]),
      .i_dat_rdy (per_dat_rdy[p]),
      .i_tvld    (r_tvld),
      .i_tag     (r_tag),
      .i_tdat    (r_tdat),
      .i_fill    (w_fill),
      .i_madr    (r_madr),
      .i_wdat    (wbf_dat),
      .o_hit     (w_hit[p]),
      .o_pend    (w_pend[p]),
      .o_padr    (w_padr[p])
    );
  end

  // Cache table: FIFO fill pointer, overwrites the oldest entry once full
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tvld <= '0;
      r_tag  <= '0;
      r_tdat <= '0;
      r_fptr <= '0;
    end else if (r_st == S_IDLE) begin
      r_tvld <= '0;
      r_fptr <= '0;
    end else if (w_fill && !r_byp) begin
      r_tvld[r_fptr] <= 1'b1;
      r_tag[r_fptr]  <= r_madr;
      r_tdat[r_fptr] <= wbf_dat;
      r_fptr         <= r_fptr + DEPTH_W'(1);
    end
  end

  always_comb begin
    w_nhit = '0;
    for (int p = 0; p < NUM_PORT; p++) w_nhit = w_nhit + HW'(w_hit[p]);
    w_hsum = {1'b0, r_hit_cnt} + (CNT_W+1)'(w_nhit);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_byp      <= 1'b0;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (r_st == S_CFG) begin
      r_byp      <= cfg_byp;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      r_hit_cnt <= w_hsum[CNT_W] ? '1 : w_hsum[CNT_W-1:0];
      if (wbf_adr_vld && wbf_adr_rdy && r_miss_cnt != '1)
        r_miss_cnt <= r_miss_cnt + CNT_W'(1);
    end
  end
endmodule
